// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffq_readout.sv
// gf180mcu_fd_sc_mcu9t5v0__dffq_readout: parallel capture of a flop bank, bit-serial MSB-first readout
module gf180mcu_fd_sc_mcu9t5v0__dffq_readout #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             VDD,
   input  logic             VSS,
   input  logic             CAP,
   input  logic [WIDTH-1:0] D,
   input  logic             SR,
   input  logic             OVF_CLR,
   output logic             SO,
   output logic             SV,
   output logic             DONE,
   output logic             OVF
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {IDLE, SHIFT} st_t;
   st_t st, st_nx;
   logic [WIDTH-1:0] sh, pb;
   logic [CW-1:0] cnt;
   logic pf, fire, last, unused_supply;
   assign unused_supply = VDD ^ VSS;
   assign fire = SV & SR;
   assign last = fire & (cnt == CW'(WIDTH - 1));
   // state register
   always_ff @(posedge CLK or negedge RN)
      if (!RN) st <= IDLE;
      else st <= st_nx;
   // next state: leave IDLE on capture, return only when a word ends with nothing queued
   always_comb begin
      st_nx = st;
      if (st == IDLE && CAP) st_nx = SHIFT;
      else if (last && !pf && !CAP) st_nx = IDLE;
   end
   // outputs decoded from registered state only
   always_comb begin
      SV = (st == SHIFT);
      SO = SV & sh[WIDTH-1];
   end
   // datapath: shifter, bit counter, pending buffer, done pulse and sticky overflow
   always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
         sh   <= '0;
         pb   <= '0;
         cnt  <= '0;
         pf   <= 1'b0;
         DONE <= 1'b0;
         OVF  <= 1'b0;
      end else begin
         DONE <= last & !pf & !CAP;
         OVF  <= (SV & CAP & !last & pf) | (OVF & !OVF_CLR);
         if (st == IDLE) begin
            if (CAP) begin
               sh  <= D;
               cnt <= '0;
            end
         end else if (last) begin
            cnt <= '0;
            if (pf) begin
               sh <= pb;
               pf <= CAP;
               if (CAP) pb <= D;
            end else sh <= CAP ? D : sh << 1;
         end else begin
            if (fire) begin
               sh  <= sh << 1;
               cnt <= cnt + 1'b1;
            end
            if (CAP && !pf) begin
               pb <= D;
               pf <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffq_readout.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__dffq_readout: randomized and directed checks against a word-queue model
module tb_gf180mcu_fd_sc_mcu9t5v0__dffq_readout;
   logic CLK = 0, RN = 0, VDD = 1, VSS = 0, CAP = 0, SR = 0, OVF_CLR = 0;
   logic [7:0] D = '0;
   logic SO, SV, DONE, OVF;
   int checks = 0, failures = 0;
   bit bq[$];
   logic [7:0] pq[$];
   logic m_done = 0, m_ovf = 0;

   gf180mcu_fd_sc_mcu9t5v0__dffq_readout #(.WIDTH(8)) dut (
      .CLK(CLK), .RN(RN), .VDD(VDD), .VSS(VSS), .CAP(CAP), .D(D), .SR(SR),
      .OVF_CLR(OVF_CLR), .SO(SO), .SV(SV), .DONE(DONE), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   function automatic logic [3:0] expv();
      return {bq.size() > 0, bq.size() > 0 ? logic'(bq[0]) : 1'b0, m_done, m_ovf};
   endfunction

   task automatic load(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) bq.push_back(w[i]);
   endtask

   task automatic model_reset();
      bq.delete();
      pq.delete();
      m_done = 0;
      m_ovf = 0;
   endtask

   // drive one cycle, advance the model at the edge, return at the following falling edge
   task automatic step(input logic cap, input logic [7:0] d, input logic sr, input logic clr);
      bit act, ovs;
      CAP = cap; D = d; SR = sr; OVF_CLR = clr;
      @(posedge CLK);
      act = bq.size() > 0;
      ovs = 0;
      m_done = 0;
      if (act && sr && bq.size() == 1) begin
         void'(bq.pop_front());
         if (pq.size() > 0) begin
            load(pq.pop_front());
            if (cap) pq.push_back(d);
         end else if (cap) load(d);
         else m_done = 1;
      end else begin
         if (act && sr) void'(bq.pop_front());
         if (cap) begin
            if (!act) load(d);
            else if (pq.size() == 0) pq.push_back(d);
            else ovs = 1;
         end
      end
      m_ovf = ovs | (m_ovf & ~clr);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RN = 0;
      model_reset();
      repeat (2) @(negedge CLK);
      checks++;
      if ({SV, SO, DONE, OVF} !== 4'b0000) begin
         failures++;
         $display("FAIL reset outs=%b required=0000", {SV, SO, DONE, OVF});
      end
      RN = 1;
      @(negedge CLK);
   endtask

   task automatic test_a5();
      logic [7:0] got = '0;
      int dones = 0;
      step(1, 8'hA5, 1, 0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({SV, SO, DONE, OVF} !== expv()) begin
            failures++;
            $display("FAIL a5_cycle%0d outs=%b required=%b", i, {SV, SO, DONE, OVF}, expv());
         end
         if (i < 8) got = {got[6:0], SO};
         dones += int'(DONE);
         step(0, 8'h00, 1, 0);
      end
      checks++;
      if (got !== 8'hA5 || dones != 1) begin
         failures++;
         $display("FAIL a5_word got=%h dones=%0d required=a5 dones=1", got, dones);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] got = '0;
      int n = 0, cyc = 0;
      logic sr;
      step(1, 8'h81, 0, 0);
      while (n < 8 && cyc < 200) begin
         sr = (cyc < 8) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
         checks++;
         if ({SV, SO, DONE, OVF} !== expv()) begin
            failures++;
            $display("FAIL bp_cycle%0d outs=%b required=%b", cyc, {SV, SO, DONE, OVF}, expv());
         end
         if (SV && sr) begin
            got = {got[6:0], SO};
            n++;
         end
         step(0, 8'h00, sr, 0);
         cyc++;
      end
      checks++;
      if (got !== 8'h81 || n != 8 || DONE !== 1'b1) begin
         failures++;
         $display("FAIL bp_word got=%h bits=%0d done=%b required=81 bits=8 done=1", got, n, DONE);
      end
      step(0, 8'h00, 1, 0);
   endtask

   task automatic test_pending();
      logic [15:0] got = '0;
      step(1, 8'hF0, 1, 0);
      for (int i = 0; i < 18; i++) begin
         checks++;
         if ({SV, SO, DONE, OVF} !== expv()) begin
            failures++;
            $display("FAIL pend_cycle%0d outs=%b required=%b", i, {SV, SO, DONE, OVF}, expv());
         end
         if (i < 16) got = {got[14:0], SO};
         step(i == 2, 8'h0F, 1, 0);
      end
      checks++;
      if (got !== 16'hF00F || OVF !== 1'b0) begin
         failures++;
         $display("FAIL pend_word got=%h ovf=%b required=f00f ovf=0", got, OVF);
      end
   endtask

   task automatic test_overflow();
      step(1, 8'h11, 1, 0);
      step(1, 8'h22, 1, 0);
      step(1, 8'h33, 1, 0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({SV, SO, DONE, OVF} !== expv()) begin
            failures++;
            $display("FAIL ovf_cycle%0d outs=%b required=%b", i, {SV, SO, DONE, OVF}, expv());
         end
         step(0, 8'h00, 1, 0);
      end
      checks++;
      if (OVF !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky ovf=%b required=1", OVF);
      end
      step(0, 8'h00, 1, 1);
      checks++;
      if (OVF !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear ovf=%b required=0", OVF);
      end
      step(1, 8'h44, 1, 0);
      step(1, 8'h55, 1, 0);
      step(1, 8'h66, 1, 1);
      checks++;
      if (OVF !== 1'b1 || m_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set_wins ovf=%b required=1", OVF);
      end
      repeat (20) step(0, 8'h00, 1, 1);
   endtask

   task automatic test_collision();
      logic [23:0] got = '0;
      step(1, 8'h9C, 1, 0);
      for (int i = 0; i < 26; i++) begin
         checks++;
         if ({SV, SO, DONE, OVF} !== expv()) begin
            failures++;
            $display("FAIL coll_cycle%0d outs=%b required=%b", i, {SV, SO, DONE, OVF}, expv());
         end
         if (i < 24) got = {got[22:0], SO};
         step(i == 0 || i == 7, i == 0 ? 8'h3E : 8'hB7, 1, 0);
      end
      checks++;
      if (got !== 24'h9C3EB7 || OVF !== 1'b0) begin
         failures++;
         $display("FAIL coll_words got=%h ovf=%b required=9c3eb7 ovf=0", got, OVF);
      end
   endtask

   task automatic test_random();
      logic cap, sr, clr;
      for (int i = 0; i < 400; i++) begin
         cap = ($urandom_range(0, 5) == 0);
         sr = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         step(cap, 8'($urandom), sr, clr);
         checks++;
         if ({SV, SO, DONE, OVF} !== expv()) begin
            failures++;
            $display("FAIL rand_cycle%0d outs=%b required=%b", i, {SV, SO, DONE, OVF}, expv());
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got = '0;
      step(1, 8'hC3, 1, 0);
      step(1, 8'h77, 1, 0);
      step(1, 8'h66, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      #2 RN = 0;
      #1;
      checks++;
      if ({SV, SO, DONE, OVF} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_async outs=%b required=0000", {SV, SO, DONE, OVF});
      end
      model_reset();
      @(negedge CLK);
      RN = 1;
      @(negedge CLK);
      checks++;
      if ({SV, SO, DONE, OVF} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle outs=%b required=0000", {SV, SO, DONE, OVF});
      end
      step(1, 8'h5A, 1, 0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({SV, SO, DONE, OVF} !== expv()) begin
            failures++;
            $display("FAIL rst5a_cycle%0d outs=%b required=%b", i, {SV, SO, DONE, OVF}, expv());
         end
         if (i < 8) got = {got[6:0], SO};
         step(0, 8'h00, 1, 0);
      end
      checks++;
      if (got !== 8'h5A) begin
         failures++;
         $display("FAIL rst5a_word got=%h required=5a", got);
      end
   endtask

   initial begin
      test_reset();
      test_a5();
      test_backpressure();
      test_pending();
      test_overflow();
      test_collision();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__dffq_readout.md
# gf180mcu_fd_sc_mcu9t5v0__dffq_readout

Parallel-capture, serial-readout companion for banks of positive-edge D flip-flops in the 9-track library characterization and test harness. On a capture strobe it samples a WIDTH-bit word of flop outputs and ships it bit-serially over a valid/ready handshake to the tester or scan sink. A one-deep pending buffer absorbs a second capture that arrives during a transfer; any capture beyond that raises a sticky overflow flag.

## Interface
- WIDTH, 8, captured word width; legal range 2..32.
- CLK  input  1  clock; all state changes on its rising edge.
- RN  input  1  asynchronous active-low reset; clears all state immediately, release is synchronous to CLK.
- VDD  input  1  supply pin; no functional effect.
- VSS  input  1  ground pin; no functional effect.
- CAP  input  1  capture strobe; D is sampled on any rising edge where CAP=1.
- D  input  WIDTH  parallel word from the flop bank under observation.
- SR  input  1  sink ready.
- SO  output  1  serial data, MSB first.
- SV  output  1  serial valid; a bit is transferred on every edge with SV=1 and SR=1.
- DONE  output  1  one-cycle pulse after the last bit of a word is accepted, when no word follows.
- OVF  output  1  sticky overflow; a capture was dropped.
- OVF_CLR  input  1  synchronous clear of OVF.

## Operation
- State: shift register SH[WIDTH-1:0], bit counter CNT (ceil(log2 WIDTH) bits), pending register PB[WIDTH-1:0], pending-full flag PF, FSM {IDLE, SHIFT}.
- Reset: FSM=IDLE; SH, PB, CNT = 0; PF=0; SO=0, SV=0, DONE=0, OVF=0.
- IDLE, CAP=1: SH<=D, CNT<=0, go to SHIFT.
- SHIFT: SV=1, SO=SH[WIDTH-1]. On SV&SR: SH shifts left with 0 fill, CNT<=CNT+1.
- Last beat (SV&SR with CNT=WIDTH-1), in priority order:
  - PF=1: SH<=PB, CNT<=0, PF<=0, stay in SHIFT (no bubble). A CAP on the same edge loads PB and sets PF, so PF remains 1.
  - PF=0, CAP=1: SH<=D, CNT<=0, stay in SHIFT.
  - PF=0, CAP=0: go to IDLE, DONE=1 for the following cycle.
- SHIFT, CAP=1, not the last beat: PF=0 loads PB<=D and sets PF=1. PF=1 drops the capture and sets OVF=1; PB is unchanged.
- OVF_CLR=1 clears OVF. If an overflow event occurs on the same edge, the set wins.
- SR may toggle freely. With SR=0, SO, SV and CNT hold. CAP handling is independent of SR.
- RN asserted mid-transfer aborts the word; no DONE is produced and PB is discarded.

## Timing
- Capture-to-first-bit latency: CAP sampled at edge k, so SV=1 and SO=D[WIDTH-1] are valid after edge k.
- Throughput with SR held at 1: one bit per cycle. Back-to-back words (pending or same-edge capture) have zero idle cycles.
- Word of WIDTH bits with SR=1 throughout: SV high for exactly WIDTH cycles. DONE goes high in the cycle after edge k+WIDTH.
- DONE and SV are never high in the same cycle.
- Outputs are registered or decoded only from registered state. SR, CAP and D have no combinational path to SO or SV.

## Test plan
- Reset, then CAP with D=8'hA5 and SR=1: SO sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then DONE pulses once and SV=0.
- Backpressure: D=8'h81, SR toggles 1,0,0,1,…: SO holds during SR=0 cycles, exactly 8 accepted bits 1000_0001 arrive, DONE fires one cycle after the 8th acceptance.
- Pending path: CAP D=8'hF0, then CAP D=8'h0F at beat 3, SR=1: 16 contiguous bits F0 then 0F, SV never drops, a single DONE at the end, OVF=0.
- Overflow: three CAPs (8'h11, 8'h22, 8'h33) within the first word: output is 11 then 22, OVF=1. OVF_CLR sets OVF=0. A simultaneous OVF_CLR and overflow leaves OVF=1.
- Last-beat collision: PF=1 and CAP on the last-beat edge: PB word follows with no bubble, the new CAP word follows that, OVF stays 0.
- Reset mid-word: RN low at beat 4 of 8'hC3: SV, SO, DONE and OVF go to 0 asynchronously. After release the FSM is in IDLE and the next CAP of 8'h5A shifts out cleanly.
